// File: rtl/cpu_defines.sv
// Shared CPU definitions: TLB geometry plus the refill walker's state and fault encodings.
package cpu_defines;

  localparam int TLB_ENTRY_NUM = 16;
  typedef logic [$clog2(TLB_ENTRY_NUM)-1:0] TLB_index_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_EVEN = 2'd1,
    RD_ODD  = 2'd2,
    WRITE   = 2'd3
  } walk_state_e;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_INVALID = 2'b01;
  localparam logic [1:0] FAULT_BUS     = 2'b10;

endpackage

// File: rtl/tlb_random.sv
// Free-running victim index: counts down from the top entry to wired, then wraps.
module tlb_random
  import cpu_defines::*;
(
  input  logic       clk,
  input  logic       rst,
  input  TLB_index_t wired,
  output TLB_index_t index
);

  localparam TLB_index_t TOP = TLB_index_t'(TLB_ENTRY_NUM - 1);

  TLB_index_t cnt_q, cnt_d;

  // wired >= cnt covers the normal wrap, wired above the count, and wired at the top (hold).
  always_comb begin
    if (wired >= cnt_q) cnt_d = TOP;
    else                cnt_d = cnt_q - TLB_index_t'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= TOP;
    else      cnt_q <= cnt_d;
  end

  assign index = cnt_q;

endmodule

// File: rtl/tlb_refill_walker.sv
// Hardware TLB refill: reads the even/odd PTE pair for a missing page and writes a random TLB slot.
module tlb_refill_walker
  import cpu_defines::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_req,
  input  logic [31:0] miss_vaddr,
  input  logic [7:0]  asid,
  input  logic [31:0] pt_base,
  input  logic [3:0]  wired,
  input  logic        flush,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        tlb_rw_we,
  output TLB_index_t  tlb_rw_index,
  output logic [31:0] entry_hi_o,
  output logic [31:0] entry_lo1_o,
  output logic [31:0] entry_lo2_o,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  walk_state_e   state_q, state_d;
  logic [18:0]   vpn2_q;
  logic [7:0]    asid_q;
  logic [31:0]   base_q, lo1_q, lo2_q, pte_even;
  TLB_index_t    idx_q, rand_idx;
  logic          abort_q, abort_d, gap_q, gap_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          capture, take_lo1, take_lo2, timed_out, aborting;
  logic          unused_vaddr_bits;

  tlb_random u_random (
    .clk   (clk),
    .rst   (rst),
    .wired (wired),
    .index (rand_idx)
  );

  assign unused_vaddr_bits = ^miss_vaddr[12:0];
  assign timed_out = (timer_q == TW'(MEM_TIMEOUT));
  assign aborting  = abort_q | flush;

  always_comb begin
    state_d    = state_q;
    abort_d    = abort_q;
    gap_d      = 1'b0;
    timer_d    = '0;
    capture    = 1'b0;
    take_lo1   = 1'b0;
    take_lo2   = 1'b0;
    mem_req    = 1'b0;
    tlb_rw_we  = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    fault_code = FAULT_NONE;
    case (state_q)
      IDLE: begin
        if (miss_req && !flush) begin
          state_d = RD_EVEN;
          capture = 1'b1;
          abort_d = 1'b0;
        end
      end
      RD_EVEN, RD_ODD: begin
        if (flush) abort_d = 1'b1;
        // The timeout cycle itself has the request dropped and carries the bus fault.
        if (timed_out) begin
          state_d = IDLE;
          abort_d = 1'b0;
          if (!aborting) begin
            fault      = 1'b1;
            fault_code = FAULT_BUS;
          end
        end else if (!gap_q) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            if (aborting) begin
              state_d = IDLE;
              abort_d = 1'b0;
            end else if (state_q == RD_EVEN) begin
              state_d  = RD_ODD;
              take_lo1 = 1'b1;
              gap_d    = 1'b1;
            end else begin
              state_d  = WRITE;
              take_lo2 = 1'b1;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (!flush) begin
          if (lo1_q[1] || lo2_q[1]) begin
            tlb_rw_we = 1'b1;
            done      = 1'b1;
          end else begin
            fault      = 1'b1;
            fault_code = FAULT_INVALID;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      abort_q <= 1'b0;
      gap_q   <= 1'b0;
      timer_q <= '0;
      vpn2_q  <= '0;
      asid_q  <= '0;
      base_q  <= '0;
      lo1_q   <= '0;
      lo2_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      gap_q   <= gap_d;
      timer_q <= timer_d;
      if (capture) begin
        vpn2_q <= miss_vaddr[31:13];
        asid_q <= asid;
        base_q <= pt_base;
      end
      if (take_lo1) lo1_q <= mem_rdata;
      // Victim index is frozen on the edge that enters WRITE.
      if (take_lo2) begin
        lo2_q <= mem_rdata;
        idx_q <= rand_idx;
      end
    end
  end

  assign pte_even     = base_q + {10'b0, vpn2_q, 3'b000};
  assign mem_addr     = (state_q == RD_ODD) ? pte_even + 32'd4 : pte_even;
  assign busy         = (state_q != IDLE);
  assign tlb_rw_index = idx_q;
  assign entry_hi_o   = {vpn2_q, 5'b0, asid_q};
  assign entry_lo1_o  = lo1_q;
  assign entry_lo2_o  = lo2_q;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed bench for tlb_refill_walker with address/result scoreboards and a victim-counter model.
module tb_tlb_refill_walker;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst, miss_req, flush, mem_ack;
  logic [31:0] miss_vaddr, pt_base, mem_rdata;
  logic [7:0]  asid;
  logic [3:0]  wired;
  logic        busy, mem_req, tlb_rw_we, done, fault;
  logic [31:0] mem_addr, entry_hi_o, entry_lo1_o, entry_lo2_o;
  logic [3:0]  tlb_rw_index;
  logic [1:0]  fault_code;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        we;
    logic        flt;
    logic [1:0]  code;
    logic [31:0] hi;
    logic [31:0] lo1;
    logic [31:0] lo2;
  } res_t;

  logic [31:0] addr_q[$];
  res_t        res_q[$];
  logic [31:0] cur_va;
  logic [7:0]  cur_asid;
  logic [3:0]  rnd_m, rnd_hist;

  tlb_refill_walker #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .miss_req     (miss_req),
    .miss_vaddr   (miss_vaddr),
    .asid         (asid),
    .pt_base      (pt_base),
    .wired        (wired),
    .flush        (flush),
    .busy         (busy),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .tlb_rw_we    (tlb_rw_we),
    .tlb_rw_index (tlb_rw_index),
    .entry_hi_o   (entry_hi_o),
    .entry_lo1_o  (entry_lo1_o),
    .entry_lo2_o  (entry_lo2_o),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  always #5 clk = ~clk;

  // Victim counter reference: 15 down to wired, wrap to 15; rnd_hist is the value before the last edge.
  always @(posedge clk) begin
    if (!rst) begin
      rnd_m    <= 4'd15;
      rnd_hist <= 4'd15;
    end else begin
      rnd_hist <= rnd_m;
      if (wired >= rnd_m) rnd_m <= 4'd15;
      else                rnd_m <= rnd_m - 4'd1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  function automatic logic [31:0] pte_even(input logic [31:0] base, input logic [31:0] va);
    return base + {10'b0, va[31:13], 3'b000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_miss(input logic [31:0] base, input logic [31:0] va,
                            input logic [7:0] as, input bit hold);
    pt_base    = base;
    miss_vaddr = va;
    asid       = as;
    cur_va     = va;
    cur_asid   = as;
    addr_q.push_back(pte_even(base, va));
    addr_q.push_back(pte_even(base, va) + 32'd4);
    miss_req = 1'b1;
    tick();
    if (!hold) begin
      miss_req   = 1'b0;
      pt_base    = $urandom();
      miss_vaddr = $urandom();
      asid       = 8'($urandom());
    end
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_req", 32'(mem_req), 32'd1);
  endtask

  task automatic serve_read(input string tag, input logic [31:0] rd, input int delay);
    logic [31:0] exp_a;
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) tick();
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    exp_a = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_addr"}, mem_addr, exp_a);
    repeat (delay) tick();
    if (delay > 0) begin
      chk({tag, "_hold_req"}, 32'(mem_req), 32'd1);
      chk({tag, "_hold_addr"}, mem_addr, exp_a);
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic push_result(input logic [31:0] rd0, input logic [31:0] rd1, input bit suppress);
    res_t e;
    logic v;
    v      = rd0[1] | rd1[1];
    e.we   = v & ~suppress;
    e.flt  = ~v & ~suppress;
    e.code = e.flt ? 2'b01 : 2'b00;
    e.hi   = {cur_va[31:13], 5'b0, cur_asid};
    e.lo1  = rd0;
    e.lo2  = rd1;
    res_q.push_back(e);
  endtask

  task automatic check_result(input string tag);
    res_t e;
    chk({tag, "_sb_depth"}, 32'(res_q.size()), 32'd1);
    if (res_q.size() > 0) begin
      e = res_q.pop_front();
      chk({tag, "_we"}, 32'(tlb_rw_we), 32'(e.we));
      chk({tag, "_done"}, 32'(done), 32'(e.we));
      chk({tag, "_fault"}, 32'(fault), 32'(e.flt));
      chk({tag, "_code"}, 32'(fault_code), 32'(e.code));
      chk({tag, "_hi"}, entry_hi_o, e.hi);
      chk({tag, "_lo1"}, entry_lo1_o, e.lo1);
      chk({tag, "_lo2"}, entry_lo2_o, e.lo2);
      if (e.we) begin
        chk({tag, "_index"}, 32'(tlb_rw_index), 32'(rnd_hist));
        chk({tag, "_index_range"}, 32'(tlb_rw_index >= wired), 32'd1);
      end
    end
  endtask

  initial begin
    logic [3:0] seq [8];
    int         cnt;
    bit         quiet;
    seq = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd15, 4'd14, 4'd13, 4'd12};

    rst = 1'b0; miss_req = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    miss_vaddr = '0; pt_base = '0; asid = '0; mem_rdata = '0; wired = 4'd12;
    cur_va = '0; cur_asid = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_we_done_fault", {28'd0, tlb_rw_we, done, fault_code}, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_index", 32'(tlb_rw_index), 32'd0);
    chk("rst_entry_hi", entry_hi_o, 32'd0);
    chk("rst_entry_lo", entry_lo1_o | entry_lo2_o, 32'd0);
    chk("rst_random", 32'(dut.u_random.index), 32'd15);
    rst = 1'b1;

    // Free-running victim counter with wired=12
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rand_seq%0d", i), 32'(dut.u_random.index), 32'(seq[i]));
      tick();
    end
    wired = 4'd15;
    tick(); chk("rand_w15_a", 32'(dut.u_random.index), 32'd15);
    tick(); chk("rand_w15_b", 32'(dut.u_random.index), 32'd15);
    wired = 4'd12;
    tick(); tick();
    chk("rand_13", 32'(dut.u_random.index), 32'd13);
    wired = 4'd14;
    tick(); chk("rand_wabove", 32'(dut.u_random.index), 32'd15);
    tick(); chk("rand_w14_dec", 32'(dut.u_random.index), 32'd14);
    tick(); chk("rand_w14_wrap", 32'(dut.u_random.index), 32'd15);
    wired = 4'd12;

    // Valid PTE pair: two reads with a one-cycle gap, then TLB write
    start_miss(32'h8000_1000, 32'h0040_2ABC, 8'h05, 1'b0);
    serve_read("t1_even", 32'h0000_1016, 2);
    chk("t1_gap", 32'(mem_req), 32'd0);
    tick();
    chk("t1_gap_end", 32'(mem_req), 32'd1);
    push_result(32'h0000_1016, 32'h0000_1056, 1'b0);
    serve_read("t1_odd", 32'h0000_1056, 0);
    chk("t1_entry_hi_const", entry_hi_o, 32'h0040_2005);
    check_result("t1");
    tick();
    chk("t1_pulse_end", {29'd0, tlb_rw_we, done, busy}, 32'd0);

    // Both V bits clear: invalid-PTE fault
    start_miss(32'h0001_0000, 32'h7FFF_E123, 8'hA5, 1'b0);
    serve_read("t2_even", 32'h0000_0000, 1);
    push_result(32'h0, 32'h0, 1'b0);
    serve_read("t2_odd", 32'h0000_0000, 0);
    check_result("t2");
    tick();
    chk("t2_fault_end", {30'd0, fault, busy}, 32'd0);

    // Flush during RD_EVEN, ack three cycles later
    start_miss(32'h0020_0000, 32'h1234_6000, 8'h33, 1'b0);
    chk("fl_addr", mem_addr, addr_q.pop_front());
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0002;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("fl_busy", 32'(busy), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (mem_req || tlb_rw_we || done || fault || busy) quiet = 1'b0;
      tick();
    end
    chk("fl_no_activity", 32'(quiet), 32'd1);
    addr_q.delete();

    // Flush during WRITE suppresses the write
    start_miss(32'h0000_4000, 32'h0000_E000, 8'h11, 1'b0);
    serve_read("fw_even", 32'h0000_0003, 0);
    tick();
    push_result(32'h0000_0003, 32'h0000_0043, 1'b1);
    serve_read("fw_odd", 32'h0000_0043, 0);
    flush = 1'b1;
    #1;
    check_result("fw");
    flush = 1'b0;
    tick();
    chk("fw_idle", 32'(busy), 32'd0);

    // Flush together with miss_req in IDLE does not start a walk
    miss_req = 1'b1; flush = 1'b1;
    tick();
    chk("idle_flush_busy", {30'd0, busy, mem_req}, 32'd0);
    miss_req = 1'b0; flush = 1'b0;
    tick();

    // Memory never acknowledges: bus-timeout fault
    start_miss(32'h0100_0000, 32'hFFFF_F000, 8'h77, 1'b0);
    chk("to_addr", mem_addr, addr_q.pop_front());
    cnt = 0;
    for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
      cnt++;
      tick();
    end
    chk("to_req_cycles", 32'(cnt), 32'(TIMEOUT));
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_code", 32'(fault_code), 32'd2);
    tick();
    chk("to_idle", {30'd0, busy, fault}, 32'd0);
    addr_q.delete();

    // Reset asserted during RD_ODD, then a stray ack
    start_miss(32'h0000_8000, 32'h0004_2000, 8'h09, 1'b0);
    serve_read("rr_even", 32'h0000_0002, 0);
    tick();
    chk("rr_odd_req", 32'(mem_req), 32'd1);
    chk("rr_odd_addr", mem_addr, addr_q.pop_front());
    rst = 1'b0;
    #1;
    chk("rr_req_drop", 32'(mem_req), 32'd0);
    chk("rr_busy_drop", 32'(busy), 32'd0);
    chk("rr_entry_clear", entry_hi_o | entry_lo1_o | mem_addr, 32'd0);
    tick();
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0006;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("rr_stray_ack", {29'd0, busy, tlb_rw_we, mem_req}, 32'd0);
    tick();
    chk("rr_still_idle", {29'd0, busy, tlb_rw_we, done}, 32'd0);

    // miss_req held high: back-to-back walks, re-accepted right after WRITE
    start_miss(32'h00C0_0000, 32'h5555_A000, 8'hC3, 1'b1);
    serve_read("bb1_even", 32'h0000_0000, 0);
    tick();
    push_result(32'h0000_0000, 32'h0000_0002, 1'b0);
    serve_read("bb1_odd", 32'h0000_0002, 0);
    check_result("bb1");
    tick();
    chk("bb_idle_gap", 32'(busy), 32'd0);
    addr_q.push_back(pte_even(pt_base, miss_vaddr));
    addr_q.push_back(pte_even(pt_base, miss_vaddr) + 32'd4);
    tick();
    chk("bb_reaccept", 32'(busy), 32'd1);
    miss_req = 1'b0;
    serve_read("bb2_even", 32'h0000_00FE, 1);
    tick();
    push_result(32'h0000_00FE, 32'h0000_0000, 1'b0);
    serve_read("bb2_odd", 32'h0000_0000, 0);
    check_result("bb2");
    tick();
    chk("bb_end", {30'd0, busy, tlb_rw_we}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
